// File: rtl/pw_psum_accum.sv
`default_nettype none
// ============================================================================
//  Module   : pw_psum_accum
//  Purpose  : Output drain stage for one column of the pointwise systolic
//             array. It accumulates NUM_TILES signed partial sums into one
//             output, applies a rounding arithmetic right shift, saturates the
//             result to OUT_BITWIDTH and queues it in a small FIFO that is
//             drained over a valid/ready interface.
//  Ports    : clk, reset      - clock, synchronous active-high reset
//             psum_in/valid   - partial sum from the column's last MAC
//             psum_ready      - a partial sum can be taken this cycle
//             shift_amt       - requantization shift, sampled on tile 0
//             out_data/sat    - FIFO head value and its clamp flag
//             out_valid/ready - downstream handshake
//             busy            - partial group, in-flight result or FIFO data
//  Revision : 1.0 - initial release
// ============================================================================
module pw_psum_accum #(
    parameter int IN_BITWIDTH  = 65,
    parameter int ACC_BITWIDTH = 72,
    parameter int OUT_BITWIDTH = 16,
    parameter int NUM_TILES    = 4,
    parameter int SHIFT_WIDTH  = 7,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [IN_BITWIDTH-1:0]  psum_in,
    input  logic                    psum_valid,
    output logic                    psum_ready,
    input  logic [SHIFT_WIDTH-1:0]  shift_amt,
    output logic [OUT_BITWIDTH-1:0] out_data,
    output logic                    out_sat,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam int C_TILE_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int C_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int C_CNT_W  = C_PTR_W + 1;

    localparam logic [C_TILE_W-1:0] C_LAST_TILE = C_TILE_W'(NUM_TILES - 1);
    localparam logic [C_CNT_W-1:0]  C_DEPTH     = C_CNT_W'(FIFO_DEPTH);

    // Saturation bounds expressed at the stage-2 working width.
    localparam logic signed [ACC_BITWIDTH:0] C_SAT_MAX =
        {{(ACC_BITWIDTH - OUT_BITWIDTH + 2){1'b0}}, {(OUT_BITWIDTH - 1){1'b1}}};
    localparam logic signed [ACC_BITWIDTH:0] C_SAT_MIN =
        {{(ACC_BITWIDTH - OUT_BITWIDTH + 2){1'b1}}, {(OUT_BITWIDTH - 1){1'b0}}};
    localparam logic [OUT_BITWIDTH-1:0] C_OUT_MAX = {1'b0, {(OUT_BITWIDTH - 1){1'b1}}};
    localparam logic [OUT_BITWIDTH-1:0] C_OUT_MIN = {1'b1, {(OUT_BITWIDTH - 1){1'b0}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [C_TILE_W-1:0]     tile_cnt_q,   tile_cnt_d;
    logic [ACC_BITWIDTH-1:0] acc_q,        acc_d;
    logic [SHIFT_WIDTH-1:0]  shift_q,      shift_d;
    logic                    p1_valid_q,   p1_valid_d;
    logic [ACC_BITWIDTH-1:0] p1_sum_q,     p1_sum_d;
    logic [SHIFT_WIDTH-1:0]  p1_shift_q,   p1_shift_d;
    logic [C_PTR_W-1:0]      wr_ptr_q,     wr_ptr_d;
    logic [C_PTR_W-1:0]      rd_ptr_q,     rd_ptr_d;
    logic [C_CNT_W-1:0]      fifo_count_q, fifo_count_d;

    logic [OUT_BITWIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   fifo_sat_q;

    // ------------------------------------------------------------------
    // Accept / accumulate
    // ------------------------------------------------------------------
    logic                    w_psum_ready;
    logic                    w_accept;
    logic                    w_first;
    logic                    w_last;
    logic [ACC_BITWIDTH-1:0] w_psum_ext;
    logic [ACC_BITWIDTH-1:0] w_group_sum;
    logic [SHIFT_WIDTH-1:0]  w_cur_shift;

    // Gate on every tile: counting the in-flight stage-1 result guarantees
    // the FIFO always has room for the push that follows a last tile.
    assign w_psum_ready = !reset &&
                          ((fifo_count_q + C_CNT_W'(p1_valid_q)) < C_DEPTH);
    assign w_accept     = psum_valid && w_psum_ready;
    assign w_first      = (tile_cnt_q == '0);
    assign w_last       = (tile_cnt_q == C_LAST_TILE);
    assign w_psum_ext   = ACC_BITWIDTH'($signed(psum_in));

    // Tile 0 starts from zero rather than the stale accumulator, which also
    // makes the single-tile configuration produce the right group sum.
    assign w_group_sum  = (w_first ? '0 : acc_q) + w_psum_ext;
    assign w_cur_shift  = w_first ? shift_amt : shift_q;

    always_comb begin
        tile_cnt_d = tile_cnt_q;
        acc_d      = acc_q;
        shift_d    = shift_q;
        p1_valid_d = 1'b0;
        p1_sum_d   = p1_sum_q;
        p1_shift_d = p1_shift_q;
        if (w_accept) begin
            acc_d = w_group_sum;
            if (w_first) begin
                shift_d = shift_amt;
            end
            if (w_last) begin
                p1_valid_d = 1'b1;
                p1_sum_d   = w_group_sum;
                p1_shift_d = w_cur_shift;
                tile_cnt_d = '0;
            end else begin
                tile_cnt_d = tile_cnt_q + C_TILE_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: rounding shift and saturation (combinational on p1_*)
    // ------------------------------------------------------------------
    logic signed [ACC_BITWIDTH:0] w_sum_ext;
    logic signed [ACC_BITWIDTH:0] w_round;
    logic signed [ACC_BITWIDTH:0] w_rounded;
    logic signed [ACC_BITWIDTH:0] w_r;
    logic [OUT_BITWIDTH-1:0]      w_res_data;
    logic                         w_res_sat;

    assign w_sum_ext = (ACC_BITWIDTH + 1)'($signed(p1_sum_q));
    // One extra bit of headroom: the rounding constant is at most
    // 2^(ACC_BITWIDTH-2) when it is used, so the add never overflows.
    assign w_round   = (p1_shift_q == '0) ? '0 :
                       ((ACC_BITWIDTH + 1)'(1) << (p1_shift_q - SHIFT_WIDTH'(1)));
    assign w_rounded = w_sum_ext + w_round;

    always_comb begin
        w_r        = w_rounded >>> p1_shift_q;
        w_res_data = w_r[OUT_BITWIDTH-1:0];
        w_res_sat  = 1'b0;
        // Shifting out every magnitude bit leaves only the sign.
        if (int'(p1_shift_q) >= ACC_BITWIDTH) begin
            w_r = w_sum_ext[ACC_BITWIDTH] ? {(ACC_BITWIDTH + 1){1'b1}} : '0;
            w_res_data = w_r[OUT_BITWIDTH-1:0];
        end
        if (w_r > C_SAT_MAX) begin
            w_res_data = C_OUT_MAX;
            w_res_sat  = 1'b1;
        end else if (w_r < C_SAT_MIN) begin
            w_res_data = C_OUT_MIN;
            w_res_sat  = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic w_out_valid;
    logic w_push;
    logic w_pop;

    assign w_out_valid = !reset && (fifo_count_q != '0);
    assign w_push      = p1_valid_q;
    assign w_pop       = w_out_valid && out_ready;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   fifo_count_d = fifo_count_q + C_CNT_W'(1);
            2'b01:   fifo_count_d = fifo_count_q - C_CNT_W'(1);
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_data_q[wr_ptr_q] <= w_res_data;
            fifo_sat_q[wr_ptr_q]  <= w_res_sat;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            tile_cnt_q   <= '0;
            acc_q        <= '0;
            shift_q      <= '0;
            p1_valid_q   <= 1'b0;
            p1_sum_q     <= '0;
            p1_shift_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            tile_cnt_q   <= tile_cnt_d;
            acc_q        <= acc_d;
            shift_q      <= shift_d;
            p1_valid_q   <= p1_valid_d;
            p1_sum_q     <= p1_sum_d;
            p1_shift_q   <= p1_shift_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (forced quiet while reset is asserted)
    // ------------------------------------------------------------------
    assign psum_ready = w_psum_ready;
    assign out_valid  = w_out_valid;
    assign out_data   = w_out_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign out_sat    = w_out_valid ? fifo_sat_q[rd_ptr_q]  : 1'b0;
    assign busy       = !reset &&
                        ((tile_cnt_q != '0) || p1_valid_q || (fifo_count_q != '0));

endmodule
`default_nettype wire

// File: tb/tb_pw_psum_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pw_psum_accum
//  Purpose  : Self-checking bench for pw_psum_accum. Stimulus tasks feed a
//             reference model that queues expected results; an independent
//             monitor pops and compares on every output handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pw_psum_accum;

    localparam int IN_W  = 65;
    localparam int ACC_W = 72;
    localparam int OUT_W = 16;
    localparam int NT    = 4;
    localparam int SW    = 7;
    localparam int FD    = 4;

    logic              clk        = 1'b0;
    logic              reset      = 1'b1;
    logic [IN_W-1:0]   psum_in    = '0;
    logic              psum_valid = 1'b0;
    logic              psum_ready;
    logic [SW-1:0]     shift_amt  = '0;
    logic [OUT_W-1:0]  out_data;
    logic              out_sat;
    logic              out_valid;
    logic              out_ready  = 1'b0;
    logic              busy;

    logic              ready_force = 1'b0;
    logic              rand_ready  = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    pw_psum_accum #(
        .IN_BITWIDTH (IN_W),
        .ACC_BITWIDTH(ACC_W),
        .OUT_BITWIDTH(OUT_W),
        .NUM_TILES   (NT),
        .SHIFT_WIDTH (SW),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .psum_in   (psum_in),
        .psum_valid(psum_valid),
        .psum_ready(psum_ready),
        .shift_amt (shift_amt),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Single writer of out_ready: either random backpressure or a forced level.
    always @(negedge clk) begin
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    // ------------------------------------------------------------------
    // Reference model: arbitrary-precision-style arithmetic on 128 bits
    // ------------------------------------------------------------------
    int                    m_tile  = 0;
    int                    m_shift = 0;
    logic signed [127:0]   m_sum   = '0;
    logic [OUT_W:0]        exp_q[$];

    function automatic logic signed [127:0] wrap_acc(input logic signed [127:0] v);
        logic signed [127:0] r;
        r = {{(128 - ACC_W){v[ACC_W-1]}}, v[ACC_W-1:0]};
        return r;
    endfunction

    // Round half up: floor((s + 2^(sh-1)) / 2^sh), then clamp.
    function automatic logic [OUT_W:0] ref_result(input logic signed [127:0] s, input int sh);
        logic signed [127:0] den, t, q, lim_hi, lim_lo;
        lim_hi = (128'sd1 <<< (OUT_W - 1)) - 128'sd1;
        lim_lo = -(128'sd1 <<< (OUT_W - 1));
        if (sh >= ACC_W) begin
            q = (s < 0) ? -128'sd1 : 128'sd0;
        end else if (sh == 0) begin
            q = s;
        end else begin
            den = 128'sd1 <<< sh;
            t   = s + (den >>> 1);
            q   = t / den;
            if (t < 0 && q * den != t) q = q - 128'sd1;
        end
        if (q > lim_hi) return {1'b1, lim_hi[OUT_W-1:0]};
        if (q < lim_lo) return {1'b1, lim_lo[OUT_W-1:0]};
        return {1'b0, q[OUT_W-1:0]};
    endfunction

    task automatic model_accept(input logic [IN_W-1:0] p, input logic [SW-1:0] sh);
        logic signed [IN_W-1:0] ps;
        logic signed [127:0]    pe;
        ps = p;
        pe = 128'(ps);
        if (m_tile == 0) begin
            m_sum   = wrap_acc(pe);
            m_shift = int'(sh);
        end else begin
            m_sum = wrap_acc(m_sum + pe);
        end
        m_tile++;
        if (m_tile == NT) begin
            exp_q.push_back(ref_result(m_sum, m_shift));
            m_tile = 0;
        end
    endtask

    // ------------------------------------------------------------------
    // Checks
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: compare every handshaken output against the scoreboard.
    always @(negedge clk) begin
        logic [OUT_W:0] e;
        #2;
        if (!reset && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got data=%0d sat=%0d, required no output",
                         $signed(out_data), out_sat);
            end else begin
                e = exp_q.pop_front();
                if ({out_sat, out_data} !== e) begin
                    n_fail++;
                    $display("FAIL output_value: got data=%0d sat=%0d, required data=%0d sat=%0d",
                             $signed(out_data), out_sat, $signed(e[OUT_W-1:0]), e[OUT_W]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic send_psum(input logic [IN_W-1:0] p, input logic [SW-1:0] sh);
        int  waits = 0;
        bit  done  = 0;
        while (!done) begin
            @(negedge clk);
            psum_valid = 1'b1;
            psum_in    = p;
            shift_amt  = sh;
            if (psum_ready) begin
                model_accept(p, sh);
                done = 1;
            end else begin
                waits++;
                if (waits > 500) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL accept_timeout: got no accept in %0d cycles, required accept", waits);
                    done = 1;
                end
            end
            @(posedge clk);
        end
    endtask

    task automatic send_group(input int p0, input int p1, input int p2, input int p3,
                              input int sh0, input int shr);
        send_psum(IN_W'(p0), SW'(sh0));
        send_psum(IN_W'(p1), SW'(shr));
        send_psum(IN_W'(p2), SW'(shr));
        send_psum(IN_W'(p3), SW'(shr));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            psum_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            psum_valid = 1'b0;
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic rand_group();
        logic [IN_W-1:0] p [NT];
        logic [95:0]     tmp;
        logic [SW-1:0]   sh;
        bit              big;
        big = ($urandom_range(0, 9) < 3);
        for (int i = 0; i < NT; i++) begin
            if (big) begin
                tmp  = {$urandom(), $urandom(), $urandom()};
                p[i] = tmp[IN_W-1:0];
            end else begin
                p[i] = IN_W'($urandom_range(0, 60000) - 30000);
            end
        end
        sh = big ? SW'($urandom_range(40, 127)) : SW'($urandom_range(0, 20));
        for (int i = 0; i < NT; i++) begin
            send_psum(p[i], (i == 0) ? sh : SW'($urandom_range(0, 127)));
        end
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    endtask

    logic [OUT_W-1:0] head;

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_out_valid",  32'(out_valid),  32'd0);
        chk("reset_busy",       32'(busy),       32'd0);
        chk("reset_psum_ready", 32'(psum_ready), 32'd0);
        chk("reset_out_data",   32'(out_data),   32'd0);
        reset = 1'b0;
        #1;
        chk("post_reset_psum_ready", 32'(psum_ready), 32'd1);

        // Basic sum with exact latency and a single-cycle valid pulse
        ready_force = 1'b1;
        idle(2);
        send_group(10, 20, 30, 40, 0, 0);
        @(negedge clk); psum_valid = 1'b0; #1;
        chk("lat_valid_t1", 32'(out_valid), 32'd0);
        chk("lat_busy_t1",  32'(busy),      32'd1);
        @(negedge clk); #1;
        chk("lat_valid_t2", 32'(out_valid), 32'd1);
        chk("lat_data_t2",  32'(out_data),  32'd100);
        @(negedge clk); #1;
        chk("lat_valid_t3", 32'(out_valid), 32'd0);
        wait_drain();

        // Rounding, saturation and shift latch (back-to-back groups)
        send_group(1, 1, 1, 2, 1, 1);              //  5 >> 1 -> 3
        send_group(-1, -1, -1, -2, 1, 1);          // -5 >> 1 -> -2
        send_group(-1, -1, -2, -2, 1, 1);          // -6 >> 1 -> -3
        send_group(6, 6, 6, 6, 4, 4);              // 24 >> 4 -> 2
        send_group(20000, 20000, 20000, 20000, 0, 0);
        send_group(-20000, -20000, -20000, -20000, 0, 0);
        send_group(8191, 8192, 8192, 8192, 0, 0);  // exactly 32767
        send_group(10, 10, 10, 10, 2, 0);          // tile-0 shift applies
        wait_drain();

        // Backpressure: five groups against a stalled consumer
        ready_force = 1'b0;
        idle(2);
        fork
            begin
                for (int g = 0; g < 5; g++) begin
                    send_group(100 * g + 1, 2, 3, 4, 0, 0);
                end
            end
            begin
                repeat (30) @(negedge clk);
                #1;
                chk("bp_psum_ready", 32'(psum_ready), 32'd0);
                chk("bp_out_valid",  32'(out_valid),  32'd1);
                chk("bp_busy",       32'(busy),       32'd1);
                chk("bp_pending",    32'(exp_q.size()), 32'd4);
                head = out_data;
                repeat (4) begin
                    @(negedge clk); #1;
                    chk("bp_head_stable", 32'(out_data), 32'(head));
                end
                ready_force = 1'b1;
            end
        join
        wait_drain();

        // Reset in the middle of a group
        idle(2);
        send_psum(IN_W'(1000), SW'(0));
        send_psum(IN_W'(1000), SW'(0));
        @(negedge clk);
        psum_valid = 1'b0;
        reset      = 1'b1;
        m_tile     = 0;
        exp_q.delete();
        #1;
        chk("midrst_out_valid",  32'(out_valid),  32'd0);
        chk("midrst_busy",       32'(busy),       32'd0);
        chk("midrst_psum_ready", 32'(psum_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_busy_after", 32'(busy), 32'd0);
        send_group(1, 1, 1, 1, 0, 0);
        wait_drain();

        // Randomized groups with random backpressure
        rand_ready = 1'b1;
        for (int g = 0; g < 40; g++) begin
            rand_group();
        end
        idle(1);
        rand_ready  = 1'b0;
        ready_force = 1'b1;
        wait_drain();
        idle(3);
        #1;
        chk("final_out_valid", 32'(out_valid), 32'd0);
        chk("final_busy",      32'(busy),      32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
